// File: rtl/tdm_mux_demux_ctrl_if.sv
// rtl/tdm_mux_demux_ctrl_if.sv - mux-side signal bundle for the TDM mux/demux controller
// A_chg/B_chg exist only when TDM_MUX_DEMUX_CHG_DET_EN is defined.
interface tdm_mux_demux_ctrl_if;
    logic Enable;
    logic Y_in;
    logic Select;
    logic A_out;
    logic B_out;
    logic A_valid;
    logic B_valid;
    logic Frame_done;
`ifdef TDM_MUX_DEMUX_CHG_DET_EN
    logic A_chg;
    logic B_chg;
`endif

    modport master (
        input  Enable,
        input  Y_in,
        output Select,
        output A_out,
        output B_out,
        output A_valid,
        output B_valid,
`ifdef TDM_MUX_DEMUX_CHG_DET_EN
        output A_chg,
        output B_chg,
`endif
        output Frame_done
    );

    modport slave (
        output Enable,
        output Y_in,
        input  Select,
        input  A_out,
        input  B_out,
        input  A_valid,
        input  B_valid,
`ifdef TDM_MUX_DEMUX_CHG_DET_EN
        input  A_chg,
        input  B_chg,
`endif
        input  Frame_done
    );
endinterface

// File: rtl/tdm_mux_demux_ctrl.sv
// rtl/tdm_mux_demux_ctrl.sv - drives 2:1 mux Select A-then-B, samples Y per slot, demuxes to A/B
// Optional per-channel change detect outputs: define TDM_MUX_DEMUX_CHG_DET_EN.
module tdm_mux_demux_ctrl #(
    parameter int DWELL = 4
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    tdm_mux_demux_ctrl_if.master bus
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, SLOT_A, SLOT_B} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          select_q, select_d;
    logic          a_out_q, a_out_d;
    logic          b_out_q, b_out_d;
    logic          a_valid_q, a_valid_d;
    logic          b_valid_q, b_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          a_chg_q, a_chg_d;
    logic          b_chg_q, b_chg_d;
    logic          slot_end;
    logic          a_hit;
    logic          b_hit;

    assign slot_end = (state_q != IDLE) && (cnt_q == LAST);
    assign a_hit    = slot_end && (state_q == SLOT_A);
    assign b_hit    = slot_end && (state_q == SLOT_B);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            select_q     <= 1'b1;
            a_out_q      <= 1'b0;
            b_out_q      <= 1'b0;
            a_valid_q    <= 1'b0;
            b_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
            a_chg_q      <= 1'b0;
            b_chg_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            select_q     <= select_d;
            a_out_q      <= a_out_d;
            b_out_q      <= b_out_d;
            a_valid_q    <= a_valid_d;
            b_valid_q    <= b_valid_d;
            frame_done_q <= frame_done_d;
            a_chg_q      <= a_chg_d;
            b_chg_q      <= b_chg_d;
        end
    end

    // Enable only matters in IDLE and at the end of SLOT_B, so frames are never cut short.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE:   if (bus.Enable) state_d = SLOT_A;
            SLOT_A: if (slot_end) state_d = SLOT_B;
                    else          cnt_d   = cnt_q + 1'b1;
            SLOT_B: if (slot_end) state_d = bus.Enable ? SLOT_A : IDLE;
                    else          cnt_d   = cnt_q + 1'b1;
            default: state_d = IDLE;
        endcase
    end

    // Select follows the next state so the mux switches on the same edge the slot changes.
    always_comb begin
        select_d     = (state_d != SLOT_B);
        a_out_d      = a_hit ? bus.Y_in : a_out_q;
        b_out_d      = b_hit ? bus.Y_in : b_out_q;
        a_valid_d    = a_hit;
        b_valid_d    = b_hit;
        frame_done_d = b_hit;
        a_chg_d      = a_hit && (bus.Y_in != a_out_q);
        b_chg_d      = b_hit && (bus.Y_in != b_out_q);
    end

    assign bus.Select     = select_q;
    assign bus.A_out      = a_out_q;
    assign bus.B_out      = b_out_q;
    assign bus.A_valid    = a_valid_q;
    assign bus.B_valid    = b_valid_q;
    assign bus.Frame_done = frame_done_q;
`ifdef TDM_MUX_DEMUX_CHG_DET_EN
    assign bus.A_chg      = a_chg_q;
    assign bus.B_chg      = b_chg_q;
`else
    logic unused_chg;
    assign unused_chg = a_chg_q ^ b_chg_q;
`endif
endmodule

// File: tb/tb_tdm_mux_demux_ctrl.sv
// tb/tb_tdm_mux_demux_ctrl.sv - randomized bench for tdm_mux_demux_ctrl with a frame-position model
// Two instances: DWELL=4 (index 0) and DWELL=1 (index 1); change detect checked under TDM_MUX_DEMUX_CHG_DET_EN.
module tb_tdm_mux_demux_ctrl;
    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    logic en [2]   = '{1'b0, 1'b0};
    logic a_in [2] = '{1'b0, 1'b0};
    logic b_in [2] = '{1'b0, 1'b0};
    int   checks = 0;
    int   failures = 0;

    always #5 Clk = ~Clk;

    tdm_mux_demux_ctrl_if bus0 ();
    tdm_mux_demux_ctrl_if bus1 ();

    assign bus0.Enable = en[0];
    assign bus1.Enable = en[1];
    assign bus0.Y_in   = bus0.Select ? a_in[0] : b_in[0];
    assign bus1.Y_in   = bus1.Select ? a_in[1] : b_in[1];

    tdm_mux_demux_ctrl #(.DWELL(4)) dut0 (.Clk(Clk), .Rst_n(Rst_n), .bus(bus0.master));
    tdm_mux_demux_ctrl #(.DWELL(1)) dut1 (.Clk(Clk), .Rst_n(Rst_n), .bus(bus1.master));

    // Reference: position within a 2*DWELL-cycle frame; A sampled at DWELL-1, B at 2*DWELL-1.
    int   dw [2]     = '{4, 1};
    int   m_pos [2]  = '{0, 0};
    bit   m_idle [2] = '{1'b1, 1'b1};
    logic m_aout [2] = '{1'b0, 1'b0};
    logic m_bout [2] = '{1'b0, 1'b0};
    logic m_aval [2] = '{1'b0, 1'b0};
    logic m_bval [2] = '{1'b0, 1'b0};
    logic m_ach [2]  = '{1'b0, 1'b0};
    logic m_bch [2]  = '{1'b0, 1'b0};

    always @(posedge Clk or negedge Rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!Rst_n) begin
                m_idle[k] = 1'b1; m_pos[k] = 0;
                m_aout[k] = 1'b0; m_bout[k] = 1'b0;
                m_aval[k] = 1'b0; m_bval[k] = 1'b0;
                m_ach[k]  = 1'b0; m_bch[k]  = 1'b0;
            end else begin
                logic y;
                y = (m_idle[k] || m_pos[k] < dw[k]) ? a_in[k] : b_in[k];
                m_aval[k] = 1'b0; m_bval[k] = 1'b0;
                m_ach[k]  = 1'b0; m_bch[k]  = 1'b0;
                if (m_idle[k]) begin
                    if (en[k]) begin m_idle[k] = 1'b0; m_pos[k] = 0; end
                end else begin
                    if (m_pos[k] == dw[k] - 1) begin
                        m_ach[k] = (y != m_aout[k]); m_aout[k] = y; m_aval[k] = 1'b1;
                    end
                    if (m_pos[k] == 2 * dw[k] - 1) begin
                        m_bch[k] = (y != m_bout[k]); m_bout[k] = y; m_bval[k] = 1'b1;
                        if (!en[k]) m_idle[k] = 1'b1;
                    end
                    m_pos[k] = (m_pos[k] + 1) % (2 * dw[k]);
                end
            end
        end
    end

    logic [7:0] expv [2];
    logic [7:0] obs [2];
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            expv[k] = {m_idle[k] || (m_pos[k] < dw[k]), m_aout[k], m_bout[k],
                       m_aval[k], m_bval[k], m_bval[k], 2'b00};
`ifdef TDM_MUX_DEMUX_CHG_DET_EN
            expv[k][1:0] = {m_ach[k], m_bch[k]};
`endif
        end
        obs[0] = {bus0.Select, bus0.A_out, bus0.B_out, bus0.A_valid, bus0.B_valid, bus0.Frame_done, 2'b00};
        obs[1] = {bus1.Select, bus1.A_out, bus1.B_out, bus1.A_valid, bus1.B_valid, bus1.Frame_done, 2'b00};
`ifdef TDM_MUX_DEMUX_CHG_DET_EN
        obs[0][1:0] = {bus0.A_chg, bus0.B_chg};
        obs[1][1:0] = {bus1.A_chg, bus1.B_chg};
`endif
    end

    task automatic test_reset();
        Rst_n = 1'b0; en[0] = 1'b0; en[1] = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge Clk); #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== 8'b1000_0000) begin
                    failures++;
                    $display("FAIL reset dut%0d cyc%0d actual=%b required=%b", k, c, obs[k], 8'b1000_0000);
                end
            end
        end
    endtask

    task automatic test_basic_frame();
        int na;
        na = 0;
        a_in[0] = 1'b1; b_in[0] = 1'b0; en[0] = 1'b1;
        for (int c = 0; c < 26; c++) begin
            @(posedge Clk); #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv[k]) begin
                    failures++;
                    $display("FAIL basic_frame dut%0d cyc%0d actual=%b required=%b", k, c, obs[k], expv[k]);
                end
            end
            // Enable seen at the first edge: SLOT_A spans cycles 0..3, A strobe lands at cycle 4, B at 8.
            if (bus0.A_valid) begin
                checks++;
                if ((c % 8) != 4 || bus0.A_out !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_a_strobe cyc%0d actual_mod8=%0d A_out=%b required_mod8=4 A_out=1", c, c % 8, bus0.A_out);
                end
                na++;
            end
        end
        checks++;
        if (na != 3) begin
            failures++;
            $display("FAIL basic_a_count actual=%0d required=3", na);
        end
    endtask

    task automatic test_enable_drop();
        int guard;
        guard = 0;
        while (!(!m_idle[0] && m_pos[0] == 1) && guard < 40) begin
            @(posedge Clk); #1; guard++;
        end
        checks++;
        if (guard >= 40) begin
            failures++;
            $display("FAIL enable_drop_sync actual=timeout required=slotA_cycle2");
        end
        en[0] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge Clk); #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv[k]) begin
                    failures++;
                    $display("FAIL enable_drop dut%0d cyc%0d actual=%b required=%b", k, c, obs[k], expv[k]);
                end
            end
        end
        checks++;
        if (obs[0] !== 8'b1100_0000) begin
            failures++;
            $display("FAIL enable_drop_idle actual=%b required=%b", obs[0], 8'b1100_0000);
        end
    endtask

    task automatic test_async_reset();
        int guard;
        guard = 0;
        a_in[0] = 1'b0; b_in[0] = 1'b1; en[0] = 1'b1;
        while (!(!m_idle[0] && m_pos[0] == dw[0] + 2) && guard < 40) begin
            @(posedge Clk); #1; guard++;
        end
        checks++;
        if (guard >= 40) begin
            failures++;
            $display("FAIL async_reset_sync actual=timeout required=slotB_cycle3");
        end
        #2 Rst_n = 1'b0;
        #1;
        checks++;
        if (obs[0] !== 8'b1000_0000) begin
            failures++;
            $display("FAIL async_reset_immediate actual=%b required=%b", obs[0], 8'b1000_0000);
        end
        @(posedge Clk); #3 Rst_n = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(posedge Clk); #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv[k]) begin
                    failures++;
                    $display("FAIL async_reset dut%0d cyc%0d actual=%b required=%b", k, c, obs[k], expv[k]);
                end
            end
        end
    endtask

    task automatic test_dwell1();
        logic prev_sel;
        a_in[1] = 1'b1; b_in[1] = 1'b1; en[1] = 1'b1;
        prev_sel = bus1.Select;
        for (int c = 0; c < 12; c++) begin
            @(posedge Clk); #1;
            checks++;
            if (obs[1] !== expv[1]) begin
                failures++;
                $display("FAIL dwell1 cyc%0d actual=%b required=%b", c, obs[1], expv[1]);
            end
            if (c >= 2) begin
                checks++;
                if (bus1.Select === prev_sel || (bus1.A_valid ^ bus1.B_valid) !== 1'b1) begin
                    failures++;
                    $display("FAIL dwell1_toggle cyc%0d actual_sel=%b av=%b bv=%b required=alternating", c, bus1.Select, bus1.A_valid, bus1.B_valid);
                end
            end
            prev_sel = bus1.Select;
        end
        checks++;
        if ({bus1.A_out, bus1.B_out} !== 2'b11) begin
            failures++;
            $display("FAIL dwell1_data actual=%b required=11", {bus1.A_out, bus1.B_out});
        end
    endtask

`ifdef TDM_MUX_DEMUX_CHG_DET_EN
    task automatic test_chg_det();
        logic seq [4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic echg [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int n;
        n = 0;
        en[0] = 1'b0; en[1] = 1'b0; Rst_n = 1'b0;
        @(posedge Clk); #1 Rst_n = 1'b1;
        a_in[0] = seq[0]; b_in[0] = 1'b0; en[0] = 1'b1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(posedge Clk); #1;
            checks++;
            if (bus0.B_chg !== 1'b0) begin
                failures++;
                $display("FAIL chg_b cyc%0d actual=%b required=0", c, bus0.B_chg);
            end
            if (bus0.A_valid) begin
                checks++;
                if (bus0.A_chg !== echg[n]) begin
                    failures++;
                    $display("FAIL chg_a frame%0d actual=%b required=%b", n, bus0.A_chg, echg[n]);
                end
                n++;
                if (n < 4) a_in[0] = seq[n];
            end else begin
                checks++;
                if (bus0.A_chg !== 1'b0) begin
                    failures++;
                    $display("FAIL chg_a_idle cyc%0d actual=%b required=0", c, bus0.A_chg);
                end
            end
        end
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL chg_frames actual=%0d required=4", n);
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++) begin
                en[k]   = ($urandom_range(0, 9) < 7);
                a_in[k] = 1'($urandom);
                b_in[k] = 1'($urandom);
            end
            if ($urandom_range(0, 99) == 0) begin
                #2 Rst_n = 1'b0;
                #2 Rst_n = 1'b1;
            end
            @(posedge Clk); #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs[k] !== expv[k]) begin
                    failures++;
                    $display("FAIL random dut%0d cyc%0d actual=%b required=%b", k, c, obs[k], expv[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_enable_drop();
        test_async_reset();
        test_dwell1();
`ifdef TDM_MUX_DEMUX_CHG_DET_EN
        test_chg_det();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tdm_mux_demux_ctrl.md
Name: tdm_mux_demux_ctrl

Overview:
- Time-division controller for the 2:1 bit mux stage.
- Drives the mux Select line in a fixed A-then-B schedule, samples the mux output Y on the last dwell cycle of each slot, and demultiplexes the samples into two registered channel outputs with one-cycle valid strobes.
- Sits alongside the mux: upstream of it (Select) and downstream of it (Y).
- Mux convention: Select=1 routes A_in, Select=0 routes B_in.

Parameters:
- DWELL, 4: cycles Select is held per slot; legal range 1..256. Counter width is max(1, clog2(DWELL)).

Ports:
- Clk  in  1  system clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- Enable  in  1  run request
- Y_in  in  1  mux output Y, synchronous to Clk
- Select  out  1  to mux Select; 1 = A slot, 0 = B slot
- A_out  out  1  last sample taken in an A slot
- B_out  out  1  last sample taken in a B slot
- A_valid  out  1  one-cycle strobe; A_out updated this cycle
- B_valid  out  1  one-cycle strobe; B_out updated this cycle
- Frame_done  out  1  one-cycle strobe, coincident with B_valid

Behaviour:
- Reset (Rst_n=0, asynchronous, any time):
  - state=IDLE, cnt=0, Select=1.
  - A_out=B_out=0; A_valid=B_valid=Frame_done=0.
  - A reset mid-slot aborts the slot; no strobe is issued.
- States: IDLE, SLOT_A, SLOT_B. All outputs are registered.
- IDLE:
  - Select=1, cnt=0.
  - Enable=1 sampled -> SLOT_A on the next edge.
- SLOT_A:
  - Select=1; cnt increments each cycle.
  - At cnt==DWELL-1:
    - A_out<=Y_in; A_valid<=1 for one cycle.
    - cnt<=0; Select<=0; -> SLOT_B.
- SLOT_B:
  - Select=0; cnt increments each cycle.
  - At cnt==DWELL-1:
    - B_out<=Y_in; B_valid<=1 and Frame_done<=1 for one cycle.
    - cnt<=0; Select<=1.
    - -> SLOT_A if Enable=1, else -> IDLE.
- Enable is sampled only in IDLE and on the last cycle of SLOT_B. Deasserting it mid-frame completes the current frame; there is never a partial frame.
- Latency and timing:
  - IDLE->SLOT_A entry: 1 cycle.
  - Frame length: 2*DWELL cycles.
  - Strobes are visible in the cycle after the sampling edge, which is the first cycle of the next slot.
- DWELL=1: Select toggles every cycle and every cycle samples. A_valid and B_valid alternate.
- A_out and B_out hold their value between strobes. They change only on their own strobe.
- A_valid and B_valid are never high in the same cycle.

Optional Feature:
- Macro: TDM_MUX_DEMUX_CHG_DET_EN.
- Defined:
  - Adds output ports A_chg and B_chg (out, 1).
  - A_chg pulses with A_valid when the new A sample differs from the previous A_out. B_chg does the same for B.
  - The first sample after reset compares against the reset value 0.
  - Both are 0 at reset.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset value check:
  - Stimulus: Rst_n=0, then hold Enable=0 for 10 cycles after release.
  - Required: Select=1, all data outputs and strobes 0, no strobes, state stays IDLE.
- Basic frame, DWELL=4:
  - Stimulus: Enable=1 held; A_in=1, B_in=0 through the mux.
  - Required: Select high for 4 cycles, then low for 4 cycles.
  - A_valid pulses with A_out=1; 4 cycles later B_valid and Frame_done pulse with B_out=0.
  - Repeats every 8 cycles.
- Enable drop mid-frame:
  - Stimulus: deassert Enable on cycle 2 of SLOT_A.
  - Required: the frame completes (A_valid, then B_valid/Frame_done), then IDLE with Select=1.
  - No further strobes.
- Async reset mid-slot:
  - Stimulus: pulse Rst_n low between clock edges on cycle 3 of SLOT_B.
  - Required: outputs go to reset values immediately; no B_valid pulse.
  - With Enable still 1, restarts at SLOT_A 1 cycle after release.
- DWELL=1:
  - Stimulus: A_in=1, B_in=1.
  - Required: Select toggles every cycle; A_valid and B_valid alternate every cycle; A_out=B_out=1 after the first frame.
- Change detect (macro defined):
  - Stimulus: A_in sequence 0,1,1,0 over four frames.
  - Required: A_chg=0,1,0,1, each coincident with A_valid.
  - B_chg=0 throughout with B_in=0.
